parity_stream_gen: RTL

PARITY_STREAM_GEN -- requirements
Module: parity_stream_gen

---
 rtl/parity_stream_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/parity_stream_gen.sv
// parity_stream_gen
//   Generator: each accepted payload word is framed as {parity, payload}.
//   The parity mode p is sampled with the word. The framed word goes into a
//   two-entry (main + skid) output buffer with valid/ready handshakes on both
//   sides.
//   Checker: verifies received framed words against chk_mode. It pulses err
//   one cycle after a bad word and keeps a saturating error count.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   p          : generator parity mode (0 = even, 1 = odd), sampled per word
//   in_valid   : input word valid
//   in_ready   : buffer can accept a word
//   tt_in      : input payload [DATA_W-1:0]
//   out_valid  : framed word valid
//   out_ready  : downstream accepts framed word
//   pdata      : framed word [DATA_W:0], parity in MSB
//   chk_valid  : received framed word valid (always accepted)
//   chk_data   : received framed word [DATA_W:0]
//   chk_mode   : checker parity mode (0 = even, 1 = odd)
//   clr_cnt    : synchronous clear of err_cnt
//   err        : one-cycle parity error pulse
//   err_cnt    : saturating parity error count [CNT_W-1:0]

module parity_stream_gen #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] tt_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   pdata,
  input  logic              chk_valid,
  input  logic [DATA_W:0]   chk_data,
  input  logic              chk_mode,
  input  logic              clr_cnt,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt
);

  // ---------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------
  logic [DATA_W:0] frame_next;
  logic            main_valid_reg;
  logic [DATA_W:0] main_data_reg;
  logic            skid_valid_reg;
  logic [DATA_W:0] skid_data_reg;
  logic            accept;
  logic            main_free;

  // XOR of the payload gives even parity; XOR with p flips it for odd mode.
  assign frame_next = {(^tt_in) ^ p, tt_in};

  // in_ready comes from buffer state only, so there is no combinational path
  // from out_ready. The rst_n term keeps it low while reset is held.
  assign in_ready  = rst_n & ~skid_valid_reg;
  assign accept    = in_valid & in_ready;
  // The main slot can take a new word this cycle if it is empty or draining.
  assign main_free = ~main_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        // The skid entry is older than any new word. in_ready is low here,
        // so no new word can arrive in the same cycle.
        main_valid_reg <= 1'b1;
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        main_valid_reg <= accept;
        if (accept) begin
          main_data_reg <= frame_next;
        end
      end
    end else if (accept) begin
      // The main slot is stalled, so the new word parks in the skid entry.
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= frame_next;
    end
  end

  assign out_valid = main_valid_reg;
  assign pdata     = main_data_reg;

  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  logic             chk_bad;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // A word with valid parity has (^chk_data) equal to chk_mode.
  assign chk_bad = chk_valid & ((^chk_data) ^ chk_mode);

  // The count updates on the same edge that raises err, so err and the new
  // count are visible together. A clear that coincides with an error keeps
  // that error.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt) begin
      cnt_next = CNT_W'(chk_bad);
    end else if (chk_bad && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      err_reg <= chk_bad;
      cnt_reg <= cnt_next;
    end
  end

  assign err     = err_reg;
  assign err_cnt = cnt_reg;

endmodule
